// File: rtl/rx_frame_ring.sv
// rx_frame_ring: multi-slot RX frame buffer for the Vthernet MAC.
// Collects bytes into a ring of equal-sized slots, commits good frames,
// drops bad/runt/oversize/no-slot frames and exposes the head slot over
// Wishbone along with status, length, control and drop counter registers.
module rx_frame_ring #(
    parameter int          SLOT_BITS = 2,
    parameter int          SLOT_AW   = 11,
    parameter int          MIN_LEN   = 60,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        rx_data_v,
    input  logic [7:0]  rx_data,
    input  logic        rx_eof,
    input  logic        rx_err,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        rx_irq
);

    localparam int NUM_SLOTS = 2 ** SLOT_BITS;
    localparam int WORD_AW   = SLOT_AW - 2;
    localparam int BANK_AW   = SLOT_BITS + WORD_AW;
    localparam int LEN_W     = SLOT_AW + 1;
    localparam int CNT_W     = SLOT_BITS + 1;

    localparam logic [CNT_W-1:0] SLOTS_FULL = CNT_W'(NUM_SLOTS);
    localparam logic [LEN_W-1:0] LEN_FULL   = LEN_W'(2 ** SLOT_AW);
    localparam logic [LEN_W-1:0] LEN_MIN    = LEN_W'(MIN_LEN);

    localparam logic [SLOT_AW:0] OFF_STATUS = (SLOT_AW+1)'(0);
    localparam logic [SLOT_AW:0] OFF_LEN    = (SLOT_AW+1)'(4);
    localparam logic [SLOT_AW:0] OFF_CTRL   = (SLOT_AW+1)'(8);
    localparam logic [SLOT_AW:0] OFF_DROP   = (SLOT_AW+1)'(12);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DROP
    } wr_state_t;

    wr_state_t state, state_next;

    logic [LEN_W-1:0]     len, len_next;
    logic [SLOT_BITS-1:0] wr_slot, rd_slot;
    logic [CNT_W-1:0]     count;
    logic                 overflow;
    logic                 irq_en;
    logic [15:0]          drop_cnt;

    logic                 byte_we;
    logic                 commit;
    logic                 drop_evt;
    logic                 set_ovf;
    logic [SLOT_AW-1:0]   wr_off;

    // Four byte lanes so one word read returns bytes 4k..4k+3 of the head slot.
    logic [7:0]           mem [4][2**BANK_AW];
    logic [LEN_W-1:0]     slot_len [NUM_SLOTS];

    logic                 wb_hit;
    logic                 wb_valid;
    logic [SLOT_AW:0]     wb_off;
    logic                 wb_in_data;
    logic                 ctrl_wr;
    logic                 release_slot;
    logic [BANK_AW-1:0]   rd_addr;
    logic [31:0]          rd_word;

    logic                 unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:3], wbs_adr_i[1:0]};

    // Write FSM state and running frame length.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            len   <= '0;
        end else begin
            state <= state_next;
            len   <= len_next;
        end
    end

    // Write FSM next state: decides per cycle whether a byte is stored,
    // the frame is committed, or the frame is dropped.
    always_comb begin
        state_next = state;
        len_next   = len;
        byte_we    = 1'b0;
        commit     = 1'b0;
        drop_evt   = 1'b0;
        set_ovf    = 1'b0;
        wr_off     = len[SLOT_AW-1:0];
        case (state)
            ST_IDLE: begin
                wr_off = '0;
                if (rx_data_v) begin
                    if (count < SLOTS_FULL) begin
                        state_next = ST_FILL;
                        byte_we    = 1'b1;
                        len_next   = LEN_W'(1);
                    end else begin
                        state_next = ST_DROP;
                        set_ovf    = 1'b1;
                        drop_evt   = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (rx_eof) begin
                    state_next = ST_IDLE;
                    if (rx_err || (len < LEN_MIN)) begin
                        drop_evt = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end else if (rx_data_v) begin
                    if (len == LEN_FULL) begin
                        state_next = ST_DROP;
                        drop_evt   = 1'b1;
                    end else begin
                        byte_we  = 1'b1;
                        len_next = len + LEN_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (rx_eof) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame storage and committed lengths; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (byte_we) begin
            mem[wr_off[1:0]][{wr_slot, wr_off[SLOT_AW-1:2]}] <= rx_data;
        end
        if (commit) begin
            slot_len[wr_slot] <= len;
        end
    end

    // Wishbone address decode and single-cycle handshake qualification.
    always_comb begin
        wb_hit       = (wbs_adr_i[31:SLOT_AW+1] == BASE_ADDR[31:SLOT_AW+1]);
        wb_valid     = wbs_stb_i & wbs_cyc_i & wb_hit & ~wbs_ack_o;
        wb_off       = wbs_adr_i[SLOT_AW:0];
        wb_in_data   = wb_off[SLOT_AW];
        ctrl_wr      = wb_valid & wbs_we_i & ~wb_in_data & (wb_off == OFF_CTRL) & wbs_sel_i[0];
        release_slot = ctrl_wr & wbs_dat_i[0] & (count != '0);
        rd_addr      = {rd_slot, wbs_adr_i[SLOT_AW-1:2]};
    end

    // Read data mux: registers or the head-slot data window.
    always_comb begin
        rd_word = '0;
        if (wb_in_data) begin
            rd_word = {mem[3][rd_addr], mem[2][rd_addr], mem[1][rd_addr], mem[0][rd_addr]};
        end else begin
            case (wb_off)
                OFF_STATUS: begin
                    rd_word[SLOT_BITS-1:0] = rd_slot;
                    rd_word[15:8]          = 8'(count);
                    rd_word[16]            = overflow;
                    rd_word[17]            = irq_en;
                end
                OFF_LEN: begin
                    if (count != '0) begin
                        rd_word = 32'(slot_len[rd_slot]);
                    end
                end
                OFF_DROP: begin
                    rd_word = {16'h0000, drop_cnt};
                end
                default: begin
                    rd_word = '0;
                end
            endcase
        end
    end

    // Slot pointers and occupancy; a same-cycle commit and release cancel in count.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_slot <= '0;
            rd_slot <= '0;
            count   <= '0;
        end else begin
            if (commit) begin
                wr_slot <= wr_slot + SLOT_BITS'(1);
            end
            if (release_slot) begin
                rd_slot <= rd_slot + SLOT_BITS'(1);
            end
            case ({commit, release_slot})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Status flags, saturating drop counter and the registered interrupt.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            drop_cnt <= '0;
            rx_irq   <= 1'b0;
        end else begin
            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && wbs_dat_i[1]) begin
                overflow <= 1'b0;
            end
            if (ctrl_wr) begin
                irq_en <= wbs_dat_i[2];
            end
            if (drop_evt && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            rx_irq <= irq_en & (count != '0);
        end
    end

    // Wishbone ack and registered read data, both one cycle after a valid request.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_valid;
            wbs_dat_o <= (wb_valid && !wbs_we_i) ? rd_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_rx_frame_ring.sv
// tb_rx_frame_ring: self-checking bench for rx_frame_ring.
// Read expectations go into a scoreboard queue when a bus read is issued and
// are popped and compared when the acknowledge returns.
module tb_rx_frame_ring;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_STAT = BASE + 32'h000;
    localparam logic [31:0] A_LEN  = BASE + 32'h004;
    localparam logic [31:0] A_CTRL = BASE + 32'h008;
    localparam logic [31:0] A_DROP = BASE + 32'h00C;
    localparam logic [31:0] A_DATA = BASE + 32'h800;

    logic        wb_clk_i = 1'b0;
    logic        rst_n;
    logic        rx_data_v;
    logic [7:0]  rx_data;
    logic        rx_eof;
    logic        rx_err;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        rx_irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        string       name;
        logic [31:0] adr;
        logic [31:0] exp;
    } vec_t;

    rx_frame_ring dut (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .rx_data_v (rx_data_v),
        .rx_data   (rx_data),
        .rx_eof    (rx_eof),
        .rx_err    (rx_err),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .rx_irq    (rx_irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Expected little-endian data word k of a frame whose bytes count up from start.
    function automatic logic [31:0] expWord(input logic [7:0] start, input int k);
        logic [7:0] b0;
        b0 = start + 8'(4 * k);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wbCycle(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat, output bit ok);
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        wbs_sel_i = 4'hF;
        ok   = 1'b0;
        rdat = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                rdat = wbs_dat_o;
                ok   = 1'b1;
                break;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        logic [31:0] e;
        bit ok;
        exp_q.push_back(exp);
        wbCycle(1'b0, adr, 32'h0, r, ok);
        e = exp_q.pop_front();
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: no ack within bound, expected %h", name, e);
        end else begin
            checkOutput(name, r, e);
        end
    endtask

    task automatic wbWrite(input string name, input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        bit ok;
        wbCycle(1'b1, adr, dat, r, ok);
        checkOutput(name, 32'(ok), 32'd1);
    endtask

    task automatic sendBytes(input int n, input logic [7:0] start);
        for (int i = 0; i < n; i++) begin
            @(negedge wb_clk_i);
            rx_data_v = 1'b1;
            rx_data   = start + 8'(i);
        end
    endtask

    task automatic sendEof(input logic err);
        @(negedge wb_clk_i);
        rx_data_v = 1'b0;
        rx_eof    = 1'b1;
        rx_err    = err;
        @(posedge wb_clk_i);
        #1;
        rx_eof = 1'b0;
        rx_err = 1'b0;
    endtask

    initial begin
        vec_t t1 [7];
        logic [31:0] r;
        bit ok;

        t1[0] = '{"t1_status", A_STAT,         32'h0000_0100};
        t1[1] = '{"t1_len",    A_LEN,          32'd64};
        t1[2] = '{"t1_data0",  A_DATA,         expWord(8'h00, 0)};
        t1[3] = '{"t1_data8",  A_DATA + 32'h20, expWord(8'h00, 8)};
        t1[4] = '{"t1_data15", A_DATA + 32'h3C, expWord(8'h00, 15)};
        t1[5] = '{"t1_drop",   A_DROP,         32'd0};
        t1[6] = '{"t1_unmap",  BASE + 32'h010, 32'h0};

        rst_n = 1'b0;
        rx_data_v = 1'b0; rx_data = 8'h00; rx_eof = 1'b0; rx_err = 1'b0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;

        repeat (3) @(posedge wb_clk_i);
        #1;
        checkOutput("rst_ack", 32'(wbs_ack_o), 32'd0);
        checkOutput("rst_irq", 32'(rx_irq), 32'd0);
        checkOutput("rst_dat", wbs_dat_o, 32'h0);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        applyStimulus("rst_status", A_STAT, 32'h0);
        applyStimulus("rst_len", A_LEN, 32'h0);
        applyStimulus("rst_drop", A_DROP, 32'h0);

        $display("[TB] single 64B frame");
        sendBytes(64, 8'h00);
        sendEof(1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(t1[i].name, t1[i].adr, t1[i].exp);
        end
        wbWrite("t1_datawr_ack", A_DATA, 32'hFFFF_FFFF);
        applyStimulus("t1_datawr_noeffect", A_DATA, expWord(8'h00, 0));
        wbCycle(1'b0, 32'h4000_0000, 32'h0, r, ok);
        checkOutput("nohit_ack", 32'(ok), 32'd0);
        wbWrite("t1_rel_ack", A_CTRL, 32'h1);
        applyStimulus("t1_status_after", A_STAT, 32'h0000_0001);
        applyStimulus("t1_len_after", A_LEN, 32'h0);

        $display("[TB] overflow with no free slot");
        for (int f = 0; f < 5; f++) begin
            sendBytes(64, 8'h50 + 8'(f));
            sendEof(1'b0);
        end
        applyStimulus("t2_status", A_STAT, 32'h0001_0401);
        applyStimulus("t2_drop", A_DROP, 32'd1);
        applyStimulus("t2_head", A_DATA, expWord(8'h50, 0));
        wbWrite("t2_clr_ack", A_CTRL, 32'h2);
        applyStimulus("t2_status_clr", A_STAT, 32'h0000_0401);
        for (int f = 0; f < 4; f++) begin
            wbWrite("t2_rel_ack", A_CTRL, 32'h1);
        end
        applyStimulus("t2_status_empty", A_STAT, 32'h0000_0001);

        $display("[TB] runt, error, min-length, max-length and oversize frames");
        sendBytes(40, 8'h00);
        sendEof(1'b0);
        sendBytes(64, 8'h00);
        sendEof(1'b1);
        applyStimulus("t3_drop_runt_err", A_DROP, 32'd3);
        applyStimulus("t3_status_none", A_STAT, 32'h0000_0001);
        sendBytes(60, 8'h20);
        sendEof(1'b0);
        applyStimulus("t3_len60", A_LEN, 32'd60);
        wbWrite("t3_rel60_ack", A_CTRL, 32'h1);
        sendBytes(2048, 8'h00);
        sendEof(1'b0);
        applyStimulus("t3_len2048", A_LEN, 32'd2048);
        applyStimulus("t3_last_word", A_DATA + 32'h7FC, expWord(8'h00, 511));
        wbWrite("t3_rel2048_ack", A_CTRL, 32'h1);
        sendBytes(2049, 8'h00);
        sendEof(1'b0);
        applyStimulus("t3_drop_oversize", A_DROP, 32'd4);
        applyStimulus("t3_status_end", A_STAT, 32'h0000_0003);

        $display("[TB] interrupt timing");
        wbWrite("t4_irqen_ack", A_CTRL, 32'h4);
        sendBytes(64, 8'h00);
        sendEof(1'b0);
        checkOutput("t4_irq_at_commit", 32'(rx_irq), 32'd0);
        @(posedge wb_clk_i);
        #1;
        checkOutput("t4_irq_high", 32'(rx_irq), 32'd1);
        wbWrite("t4_rel_ack", A_CTRL, 32'h5);
        checkOutput("t4_irq_at_release", 32'(rx_irq), 32'd1);
        @(posedge wb_clk_i);
        #1;
        checkOutput("t4_irq_low", 32'(rx_irq), 32'd0);
        applyStimulus("t4_status_wrap", A_STAT, 32'h0002_0000);

        $display("[TB] commit and release in the same cycle");
        sendBytes(64, 8'h10);
        sendEof(1'b0);
        sendBytes(64, 8'h80);
        @(negedge wb_clk_i);
        rx_data_v = 1'b0;
        rx_eof    = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = A_CTRL;
        wbs_dat_i = 32'h5;
        wbs_sel_i = 4'hF;
        @(posedge wb_clk_i);
        #1;
        checkOutput("t5_ack", 32'(wbs_ack_o), 32'd1);
        rx_eof    = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        applyStimulus("t5_status", A_STAT, 32'h0002_0101);
        applyStimulus("t5_len", A_LEN, 32'd64);
        applyStimulus("t5_head", A_DATA, expWord(8'h80, 0));

        $display("[TB] reset in the middle of a frame");
        sendBytes(30, 8'h00);
        @(negedge wb_clk_i);
        rst_n     = 1'b0;
        rx_data_v = 1'b0;
        #1;
        checkOutput("t6_ack", 32'(wbs_ack_o), 32'd0);
        checkOutput("t6_irq", 32'(rx_irq), 32'd0);
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        applyStimulus("t6_status_rst", A_STAT, 32'h0);
        sendBytes(64, 8'hC0);
        sendEof(1'b0);
        applyStimulus("t6_status", A_STAT, 32'h0000_0100);
        applyStimulus("t6_data0", A_DATA, expWord(8'hC0, 0));
        applyStimulus("t6_data15", A_DATA + 32'h3C, expWord(8'hC0, 15));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
